mem_stage: RTL and testbench

Memory pipeline stage of the rv32imc core: sits between `ex_stage` and `wb_stage`. It turns the execute result of a load or store into a single data-memory request:

- word-aligned address, byte mask, and lane-shifted store data.
- tracks the outstanding request with a small FSM so no second request issues before `dmem_resp`.
- latches `mem_stage_reg`, which `wb_stage` consumes to select, sign-extend and write back load data.

---
 rtl/mem_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage between ex_stage and wb_stage.
// Issues one word-aligned data-memory request per load/store, tracks the
// outstanding request (IDLE/WAIT) and latches mem_stage_reg for wb_stage.
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress misaligned
// half/word accesses and report them on o_misalign.

package mem_stage_pkg;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic regf_we;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [31:0] func_out;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
    rvfi_t       rvfi;
  } ex_stage_t;

  typedef struct packed {
    logic [31:0] func_out;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    mem_ctrl_t   mem_ctrl;
    wb_ctrl_t    wb_ctrl;
    rvfi_t       rvfi;
  } mem_stage_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic        mem_flush,
  input  ex_stage_t   ex_stage_reg,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp,
  output logic        o_busy,
  output logic        o_resp_err,
  output logic [31:0] o_load_cnt,
  output logic [31:0] o_store_cnt,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic        o_misalign,
`endif
  output mem_stage_t  mem_stage_reg
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;
  mem_stage_t  mem_stage_q, mem_stage_d;

  logic        mem_op;
  logic [1:0]  byte_off;
  logic [3:0]  byte_mask;
  logic [31:0] store_data;
  logic        misalign;
  logic        try_issue;
  logic        issue;

  // Access decode: byte lanes, store-data alignment and misalignment detect.
  always_comb begin
    mem_op     = (ex_stage_reg.mem_ctrl.mem_read | ex_stage_reg.mem_ctrl.mem_write)
                 & ex_stage_reg.rvfi.valid;
    byte_off   = ex_stage_reg.func_out[1:0];
    byte_mask  = 4'b1111;
    store_data = ex_stage_reg.rs2_rdata;
    misalign   = 1'b0;
    case (ex_stage_reg.mem_ctrl.mem_funct3[1:0])
      2'b00: begin
        byte_mask  = 4'b0001 << byte_off;
        store_data = ex_stage_reg.rs2_rdata << {byte_off, 3'b000};
      end
      2'b01: begin
        byte_mask  = 4'b0011 << {byte_off[1], 1'b0};
        store_data = ex_stage_reg.rs2_rdata << {byte_off[1], 4'b0000};
`ifdef MEM_MISALIGN_CHECK_EN
        misalign   = byte_off[0];
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_CHECK_EN
        misalign   = (byte_off != 2'b00);
`endif
      end
    endcase
    // Reset gates the request so the dmem outputs read zero while rst is low.
    try_issue = rst & (state_q == S_IDLE) & mem_op & ~mem_stall & ~mem_flush;
    issue     = try_issue & ~misalign;
  end

  // Request outputs: nonzero only in the issue cycle.
  always_comb begin
    dmem_addr  = 32'd0;
    dmem_rmask = 4'd0;
    dmem_wmask = 4'd0;
    dmem_wdata = 32'd0;
    if (issue) begin
      dmem_addr = {ex_stage_reg.func_out[31:2], 2'b00};
      if (ex_stage_reg.mem_ctrl.mem_read) begin
        dmem_rmask = byte_mask;
      end
      if (ex_stage_reg.mem_ctrl.mem_write) begin
        dmem_wmask = byte_mask;
        dmem_wdata = store_data;
      end
    end
  end

  // Next-state: request FSM, sticky error, issue counters.
  always_comb begin
    state_d     = state_q;
    resp_err_d  = resp_err_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_WAIT;
        end
        if (dmem_resp) begin
          resp_err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue && ex_stage_reg.mem_ctrl.mem_read) begin
      load_cnt_d = load_cnt_q + 32'd1;
    end
    if (issue && ex_stage_reg.mem_ctrl.mem_write) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
  end

  // Next pipeline register: bubble on flush, hold on stall, else load from ex.
  always_comb begin
    mem_stage_d = mem_stage_q;
    if (mem_flush || !mem_stall) begin
      mem_stage_d.func_out       = ex_stage_reg.func_out;
      mem_stage_d.rs2_rdata      = ex_stage_reg.rs2_rdata;
      mem_stage_d.rd_addr        = ex_stage_reg.rd_addr;
      mem_stage_d.mem_ctrl       = ex_stage_reg.mem_ctrl;
      mem_stage_d.wb_ctrl        = ex_stage_reg.wb_ctrl;
      mem_stage_d.rvfi           = ex_stage_reg.rvfi;
      mem_stage_d.rvfi.mem_addr  = dmem_addr;
      mem_stage_d.rvfi.mem_rmask = dmem_rmask;
      mem_stage_d.rvfi.mem_wmask = dmem_wmask;
      mem_stage_d.rvfi.mem_wdata = dmem_wdata;
      // A suppressed misaligned access must not write the register file.
      if (try_issue && misalign) begin
        mem_stage_d.wb_ctrl.regf_we = 1'b0;
      end
      if (mem_flush) begin
        mem_stage_d.rvfi.valid      = 1'b0;
        mem_stage_d.wb_ctrl.regf_we = 1'b0;
        mem_stage_d.mem_ctrl        = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      resp_err_q  <= 1'b0;
      load_cnt_q  <= 32'd0;
      store_cnt_q <= 32'd0;
      mem_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      resp_err_q  <= resp_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      mem_stage_q <= mem_stage_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle pulse after a misaligned access is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= try_issue & misalign;
    end
  end

  assign o_misalign = misalign_q;
`endif

  assign o_busy        = (state_q == S_WAIT);
  assign o_resp_err    = resp_err_q;
  assign o_load_cnt    = load_cnt_q;
  assign o_store_cnt   = store_cnt_q;
  assign mem_stage_reg = mem_stage_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// 1 time unit later, well away from the next edge.

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_stall;
  logic        mem_flush;
  ex_stage_t   ex_stage_reg;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic        o_busy;
  logic        o_resp_err;
  logic [31:0] o_load_cnt;
  logic [31:0] o_store_cnt;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        o_misalign;
`endif
  mem_stage_t  mem_stage_reg;

  int n_cmp;
  int n_mis;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_stall    (mem_stall),
    .mem_flush    (mem_flush),
    .ex_stage_reg (ex_stage_reg),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_resp    (dmem_resp),
    .o_busy       (o_busy),
    .o_resp_err   (o_resp_err),
    .o_load_cnt   (o_load_cnt),
    .o_store_cnt  (o_store_cnt),
`ifdef MEM_MISALIGN_CHECK_EN
    .o_misalign   (o_misalign),
`endif
    .mem_stage_reg(mem_stage_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_stage_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] data);
    ex_stage_t e;
    e = '0;
    e.func_out            = addr;
    e.rs2_rdata           = data;
    e.rd_addr             = 5'd5;
    e.mem_ctrl.mem_read   = rd;
    e.mem_ctrl.mem_write  = wr;
    e.mem_ctrl.mem_funct3 = f3;
    e.wb_ctrl.regf_we     = ~wr;
    e.rvfi.valid          = 1'b1;
    e.rvfi.pc             = 32'h0000_0100;
    return e;
  endfunction

  localparam logic [2:0] F_B = 3'b000;
  localparam logic [2:0] F_H = 3'b001;
  localparam logic [2:0] F_W = 3'b010;

  initial begin
    n_cmp        = 0;
    n_mis        = 0;
    rst          = 1'b1;
    mem_stall    = 1'b0;
    mem_flush    = 1'b0;
    dmem_resp    = 1'b0;
    ex_stage_reg = mk(1'b0, 1'b1, F_B, 32'h0000_1003, 32'h0000_00AB);
    #1 rst = 1'b0;
    #1;
    // Reset state: outputs zero even with a store waiting in ex.
    check("rst_addr",  dmem_addr, 32'h0);
    check("rst_wmask", 32'(dmem_wmask), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    check("rst_err",   32'(o_resp_err), 32'h0);
    check("rst_lcnt",  o_load_cnt, 32'h0);
    check("rst_scnt",  o_store_cnt, 32'h0);
    check("rst_valid", 32'(mem_stage_reg.rvfi.valid), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    // Store byte at offset 3.
    check("sb_addr",  dmem_addr, 32'h0000_1000);
    check("sb_wmask", 32'(dmem_wmask), 32'h8);
    check("sb_rmask", 32'(dmem_rmask), 32'h0);
    check("sb_wdata", dmem_wdata, 32'hAB00_0000);
    tick();
    ex_stage_reg = '0;
    dmem_resp    = 1'b1;
    check("sb_busy",     32'(o_busy), 32'h1);
    check("sb_scnt",     o_store_cnt, 32'h1);
    check("sb_rv_wmask", 32'(mem_stage_reg.rvfi.mem_wmask), 32'h8);
    check("sb_rv_wdata", mem_stage_reg.rvfi.mem_wdata, 32'hAB00_0000);
    check("sb_rv_addr",  mem_stage_reg.rvfi.mem_addr, 32'h0000_1000);
    check("sb_rv_valid", 32'(mem_stage_reg.rvfi.valid), 32'h1);
    tick();
    dmem_resp = 1'b0;
    check("sb_idle", 32'(o_busy), 32'h0);
    check("sb_err",  32'(o_resp_err), 32'h0);

    // Load half at 0x2002, response three cycles after issue.
    ex_stage_reg = mk(1'b1, 1'b0, F_H, 32'h0000_2002, 32'h0);
    #1;
    check("lh_rmask", 32'(dmem_rmask), 32'hC);
    check("lh_addr",  dmem_addr, 32'h0000_2000);
    check("lh_wmask", 32'(dmem_wmask), 32'h0);
    tick();
    ex_stage_reg = '0;
    check("lh_busy1", 32'(o_busy), 32'h1);
    check("lh_lcnt",  o_load_cnt, 32'h1);
    tick();
    check("lh_busy2", 32'(o_busy), 32'h1);
    tick();
    dmem_resp = 1'b1;
    check("lh_busy3", 32'(o_busy), 32'h1);
    tick();
    dmem_resp = 1'b0;
    check("lh_idle", 32'(o_busy), 32'h0);

    // Back-to-back loads: second one held until the first completes.
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_3000, 32'h0);
    #1;
    check("b2b_rmask1", 32'(dmem_rmask), 32'hF);
    tick();
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_3004, 32'h0);
    #1;
    check("b2b_busy",  32'(o_busy), 32'h1);
    check("b2b_hold1", 32'(dmem_rmask), 32'h0);
    tick();
    dmem_resp = 1'b1;
    #1;
    check("b2b_hold2", 32'(dmem_rmask), 32'h0);
    tick();
    dmem_resp = 1'b0;
    #1;
    check("b2b_free",   32'(o_busy), 32'h0);
    check("b2b_rmask2", 32'(dmem_rmask), 32'hF);
    check("b2b_addr2",  dmem_addr, 32'h0000_3004);
    tick();
    ex_stage_reg = '0;
    check("b2b_lcnt",     o_load_cnt, 32'h3);
    check("b2b_busy2",    32'(o_busy), 32'h1);
    check("b2b_rv_addr",  mem_stage_reg.rvfi.mem_addr, 32'h0000_3004);
    check("b2b_rv_rmask", 32'(mem_stage_reg.rvfi.mem_rmask), 32'hF);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;

    // Stall holds the stage and blocks the store; then it issues.
    ex_stage_reg = mk(1'b0, 1'b0, F_W, 32'h0000_0055, 32'h0);
    tick();
    ex_stage_reg = mk(1'b0, 1'b1, F_W, 32'h0000_4000, 32'h1234_5678);
    mem_stall    = 1'b1;
    #1;
    check("stall_wmask", 32'(dmem_wmask), 32'h0);
    check("stall_addr",  dmem_addr, 32'h0);
    tick();
    check("stall_hold", mem_stage_reg.func_out, 32'h0000_0055);
    check("stall_scnt", o_store_cnt, 32'h1);
    check("stall_busy", 32'(o_busy), 32'h0);
    mem_stall = 1'b0;
    #1;
    check("sw_wmask", 32'(dmem_wmask), 32'hF);
    check("sw_wdata", dmem_wdata, 32'h1234_5678);
    tick();
    check("sw_scnt", o_store_cnt, 32'h2);
    check("sw_busy", 32'(o_busy), 32'h1);
    check("sw_msr",  mem_stage_reg.func_out, 32'h0000_4000);

    // Flush beats stall and does not cancel the outstanding store.
    mem_stall    = 1'b1;
    mem_flush    = 1'b1;
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_4100, 32'h0);
    tick();
    check("fl_valid", 32'(mem_stage_reg.rvfi.valid), 32'h0);
    check("fl_we",    32'(mem_stage_reg.wb_ctrl.regf_we), 32'h0);
    check("fl_ctrl",  32'(mem_stage_reg.mem_ctrl), 32'h0);
    check("fl_busy",  32'(o_busy), 32'h1);
    mem_stall    = 1'b0;
    mem_flush    = 1'b0;
    ex_stage_reg = '0;
    dmem_resp    = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("fl_idle", 32'(o_busy), 32'h0);

    // Stray response in IDLE: sticky error.
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("stray_err1", 32'(o_resp_err), 32'h1);
    tick();
    check("stray_err2", 32'(o_resp_err), 32'h1);

    // Reset during WAIT clears everything at once.
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_5000, 32'h0);
    tick();
    check("rw_busy", 32'(o_busy), 32'h1);
    check("rw_lcnt", o_load_cnt, 32'h4);
    rst = 1'b0;
    #1;
    check("rw_busy0",  32'(o_busy), 32'h0);
    check("rw_rmask",  32'(dmem_rmask), 32'h0);
    check("rw_addr",   dmem_addr, 32'h0);
    check("rw_lcnt0",  o_load_cnt, 32'h0);
    check("rw_scnt0",  o_store_cnt, 32'h0);
    check("rw_err0",   32'(o_resp_err), 32'h0);
    check("rw_valid0", 32'(mem_stage_reg.rvfi.valid), 32'h0);
    ex_stage_reg = '0;
    tick();
    rst       = 1'b1;
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("rw_stray", 32'(o_resp_err), 32'h1);
    check("rw_idle",  32'(o_busy), 32'h0);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word is dropped and flagged.
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_1001, 32'h0);
    #1;
    check("mis_rmask", 32'(dmem_rmask), 32'h0);
    check("mis_addr",  dmem_addr, 32'h0);
    tick();
    ex_stage_reg = '0;
    check("mis_pulse", 32'(o_misalign), 32'h1);
    check("mis_we",    32'(mem_stage_reg.wb_ctrl.regf_we), 32'h0);
    check("mis_rvmsk", 32'(mem_stage_reg.rvfi.mem_rmask), 32'h0);
    check("mis_busy",  32'(o_busy), 32'h0);
    check("mis_lcnt",  o_load_cnt, 32'h0);
    tick();
    check("mis_pulse0", 32'(o_misalign), 32'h0);
    ex_stage_reg = mk(1'b0, 1'b1, F_H, 32'h0000_6003, 32'h1234_BEEF);
    #1;
    check("mis_sh_wmask", 32'(dmem_wmask), 32'h0);
    tick();
    ex_stage_reg = '0;
    check("mis_sh_scnt", o_store_cnt, 32'h0);
`else
    // Without the check, low address bits are ignored for half/word.
    ex_stage_reg = mk(1'b1, 1'b0, F_W, 32'h0000_1001, 32'h0);
    #1;
    check("ua_rmask", 32'(dmem_rmask), 32'hF);
    check("ua_addr",  dmem_addr, 32'h0000_1000);
    tick();
    ex_stage_reg = '0;
    check("ua_lcnt", o_load_cnt, 32'h1);
    check("ua_busy", 32'(o_busy), 32'h1);
    dmem_resp = 1'b1;
    tick();
    dmem_resp    = 1'b0;
    ex_stage_reg = mk(1'b0, 1'b1, F_H, 32'h0000_6003, 32'h1234_BEEF);
    #1;
    check("sh_wmask", 32'(dmem_wmask), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_0000);
    check("sh_addr",  dmem_addr, 32'h0000_6000);
    tick();
    ex_stage_reg = '0;
    check("sh_scnt", o_store_cnt, 32'h1);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
